// File: rtl/ub_skew_reader_if.sv
// Bus bundle for ub_skew_reader: controller handshake, unified-buffer read
// port and the skewed systolic-array left-edge feed.
// The stride input exists only when UB_READER_STRIDE_EN is defined.
interface ub_skew_reader_if #(
    parameter int SA_LENGTH  = 2,
    parameter int ADDR_WIDTH = 3,
    parameter int NO_BANKS   = 4
);
    localparam int AddrWidth = ADDR_WIDTH + $clog2(NO_BANKS);
    localparam int DataWidth = 8 * SA_LENGTH;

    logic                 start;
    logic [AddrWidth-1:0] base_addr;
    logic [AddrWidth:0]   num_rows;
`ifdef UB_READER_STRIDE_EN
    logic [AddrWidth-1:0] stride;
`endif
    logic                 busy;
    logic                 done;
    logic [AddrWidth-1:0] ub_rdaddr;
    logic [DataWidth-1:0] ub_rddata;
    logic [DataWidth-1:0] sa_data;
    logic [SA_LENGTH-1:0] sa_valid;

`ifdef UB_READER_STRIDE_EN
    modport master (
        output start, base_addr, num_rows, stride, ub_rddata,
        input  busy, done, ub_rdaddr, sa_data, sa_valid
    );
    modport slave (
        input  start, base_addr, num_rows, stride, ub_rddata,
        output busy, done, ub_rdaddr, sa_data, sa_valid
    );
`else
    modport master (
        output start, base_addr, num_rows, ub_rddata,
        input  busy, done, ub_rdaddr, sa_data, sa_valid
    );
    modport slave (
        input  start, base_addr, num_rows, ub_rddata,
        output busy, done, ub_rdaddr, sa_data, sa_valid
    );
`endif
endinterface

// File: rtl/ub_skew_reader.sv
// Unified-buffer skew reader: issues a burst of sequential buffer reads,
// absorbs the 1-cycle read latency and delays lane i by i cycles so the
// systolic array receives a diagonal wavefront. Optional macro
// UB_READER_STRIDE_EN adds a latched address stride (accumulated, no multiply).
//
// state | meaning
// IDLE  | waiting for start; ub_rdaddr holds its last value
// ISSUE | one buffer read per enabled cycle, rows_left counts down
// DRAIN | skew pipeline emptying; done when drain_cnt reaches 0
module ub_skew_reader #(
    parameter int SA_LENGTH  = 2,
    parameter int ADDR_WIDTH = 3,
    parameter int NO_BANKS   = 4
) (
    input logic               CLK,
    input logic               SYNC_RST,
    input logic               EN,
    ub_skew_reader_if.slave   bus
);
    localparam int AddrWidth = ADDR_WIDTH + $clog2(NO_BANKS);
    localparam int DataWidth = 8 * SA_LENGTH;
    localparam int CntWidth  = $clog2(SA_LENGTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]                 state;
    logic [AddrWidth-1:0]       rd_addr;
    logic [AddrWidth-1:0]       rows_left;
    logic [CntWidth-1:0]        drain_cnt;
    logic [AddrWidth-1:0]       stride_r;
    logic                       rd_pending;
    logic [SA_LENGTH-1:0][7:0]  lane_data;
    logic [SA_LENGTH-1:0]       lane_valid;

`ifdef UB_READER_STRIDE_EN
    // Stride is captured with start so it cannot change mid-burst.
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            stride_r <= '0;
        end else if (EN && state == IDLE && bus.start) begin
            stride_r <= bus.stride;
        end
    end
`else
    assign stride_r = AddrWidth'(1);
`endif

    // Burst sequencing: address generation, row and drain down-counters.
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            state      <= IDLE;
            rd_addr    <= '0;
            rows_left  <= '0;
            drain_cnt  <= '0;
            rd_pending <= 1'b0;
        end else if (EN) begin
            rd_pending <= (state == ISSUE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.num_rows == '0) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            state     <= ISSUE;
                            rd_addr   <= bus.base_addr;
                            // 2^AddrWidth rows truncates to 0, minus 1 gives all-ones.
                            rows_left <= bus.num_rows[AddrWidth-1:0] - AddrWidth'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (rows_left == '0) begin
                        state     <= DRAIN;
                        drain_cnt <= CntWidth'(SA_LENGTH);
                    end else begin
                        rows_left <= rows_left - AddrWidth'(1);
                        rd_addr   <= rd_addr + stride_r;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - CntWidth'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-lane delay line: lane i passes through i+1 registers, the last of
    // which drives the array. Bubbles carry 0x00 so the array sees zeros.
    for (genvar i = 0; i < SA_LENGTH; i++) begin : g_lane
        logic [7:0] pipe_d [0:i];
        logic       pipe_v [0:i];

        // Shift the lane's byte and valid one stage per enabled cycle.
        always_ff @(posedge CLK) begin
            if (SYNC_RST) begin
                for (int j = 0; j <= i; j++) begin
                    pipe_d[j] <= 8'h00;
                    pipe_v[j] <= 1'b0;
                end
            end else if (EN) begin
                pipe_d[0] <= rd_pending ? bus.ub_rddata[8*i +: 8] : 8'h00;
                pipe_v[0] <= rd_pending;
                for (int j = 1; j <= i; j++) begin
                    pipe_d[j] <= pipe_d[j-1];
                    pipe_v[j] <= pipe_v[j-1];
                end
            end
        end

        assign lane_data[i]  = pipe_d[i];
        assign lane_valid[i] = pipe_v[i];
    end

    assign bus.sa_data   = DataWidth'(lane_data);
    assign bus.sa_valid  = lane_valid;
    assign bus.ub_rdaddr = rd_addr;
    assign bus.busy      = (state != IDLE);
    // A pending done is masked during a stall and reappears once EN returns.
    assign bus.done      = EN && (state == DRAIN) && (drain_cnt == '0);
endmodule
